// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
// Build option: define ALARM_BLINK_EN to make the alarm output blink
// (1 s on / 1 s off) while ringing instead of staying steadily on.
package alarm_pkg;

   localparam int HR_MAX  = 23;
   localparam int MIN_MAX = 59;
   localparam int HR_W    = 5;
   localparam int MIN_W   = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_e;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alarm_time_reg.sv
// Settable alarm time: hour and minute registers that step by one on
// their increment pulse while in set mode, wrapping at 23 and 59.
module alarm_time_reg
   import alarm_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             setMode_i,
   input  logic             incHr_i,
   input  logic             incMin_i,
   output logic [HR_W-1:0]  almHr_o,
   output logic [MIN_W-1:0] almMin_o
);

   logic [HR_W-1:0]  almHr_q,  almHr_d;
   logic [MIN_W-1:0] almMin_q, almMin_d;

   // Next alarm time: each pulse is honoured only in set mode, and both may apply together
   always_comb begin
      almHr_d  = almHr_q;
      almMin_d = almMin_q;
      if (setMode_i && incHr_i) begin
         almHr_d = (almHr_q == HR_W'(HR_MAX)) ? '0 : almHr_q + 1'b1;
      end
      if (setMode_i && incMin_i) begin
         almMin_d = (almMin_q == MIN_W'(MIN_MAX)) ? '0 : almMin_q + 1'b1;
      end
   end

   // Alarm time registers, cleared to 00:00 by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         almHr_q  <= '0;
         almMin_q <= '0;
      end else begin
         almHr_q  <= almHr_d;
         almMin_q <= almMin_d;
      end
   end

   assign almHr_o  = almHr_q;
   assign almMin_o = almMin_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: compares the alarm time with the running clock and runs
// the IDLE / RING / SNOOZE state machine that drives the alarm output.
// Build option: ALARM_BLINK_EN gates the output with a 1 Hz blink in RING.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [HR_W-1:0]  cur_hr,
   input  logic [MIN_W-1:0] cur_min,
   input  logic             sec_tick,
   input  logic             set_mode,
   input  logic             inc_hr,
   input  logic             inc_min,
   input  logic             alm_en,
   input  logic             snooze,
   input  logic             stop,
   output logic [HR_W-1:0]  alm_hr,
   output logic [MIN_W-1:0] alm_min,
   output logic             alrm_on,
   output logic [1:0]       state,
   output logic [1:0]       snooze_cnt
);

   localparam int CNT_W = $clog2(maxOf(RING_SECS, SNOOZE_SECS) + 1);
   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
   localparam logic [1:0]       SNOOZE_LIM  = 2'(MAX_SNOOZE);

   alarm_state_e     state_q, state_d;
   logic [CNT_W-1:0] secCnt_q, secCnt_d;
   logic [1:0]       snoozeCnt_q, snoozeCnt_d;
   logic             match_q;
   logic             alrmOn_q, alrmOn_d;
   logic             match;
   logic             trigger;

   alarm_time_reg uTimeReg (
      .clk_i     (clk),
      .rst_i     (rst),
      .setMode_i (set_mode),
      .incHr_i   (inc_hr),
      .incMin_i  (inc_min),
      .almHr_o   (alm_hr),
      .almMin_o  (alm_min)
   );

   // Only the first cycle of a match can start an alarm, so stopping inside the matched minute is final
   always_comb begin
      match   = (cur_hr == alm_hr) && (cur_min == alm_min);
      trigger = match && !match_q && alm_en && !set_mode;
   end

   // Next state: disarm/set mode beats stop, stop beats the per-state rules; the ring timeout beats a snooze in the same cycle
   always_comb begin
      state_d     = state_q;
      secCnt_d    = secCnt_q;
      snoozeCnt_d = snoozeCnt_q;
      if (!alm_en || set_mode || stop) begin
         state_d     = IDLE;
         secCnt_d    = '0;
         snoozeCnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d     = RING;
                  secCnt_d    = '0;
                  snoozeCnt_d = '0;
               end
            end
            RING: begin
               if (sec_tick && (secCnt_q == RING_LAST)) begin
                  state_d     = IDLE;
                  secCnt_d    = '0;
                  snoozeCnt_d = '0;
               end else if (snooze && (snoozeCnt_q < SNOOZE_LIM)) begin
                  state_d     = SNOOZE;
                  secCnt_d    = '0;
                  snoozeCnt_d = snoozeCnt_q + 1'b1;
               end else if (sec_tick) begin
                  secCnt_d = secCnt_q + 1'b1;
               end
            end
            SNOOZE: begin
               if (sec_tick) begin
                  if (secCnt_q == SNOOZE_LAST) begin
                     state_d  = RING;
                     secCnt_d = '0;
                  end else begin
                     secCnt_d = secCnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d     = IDLE;
               secCnt_d    = '0;
               snoozeCnt_d = '0;
            end
         endcase
      end
   end

`ifdef ALARM_BLINK_EN
   logic blink_q, blink_d;

   // Blink phase restarts "on" at each RING entry and flips every second while ringing
   always_comb begin
      blink_d = blink_q;
      if (state_d == RING) begin
         if (state_q != RING) begin
            blink_d = 1'b1;
         end else if (sec_tick) begin
            blink_d = !blink_q;
         end
      end
      alrmOn_d = (state_d == RING) && blink_d;
   end

   // Blink phase register
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_q <= 1'b1;
      end else begin
         blink_q <= blink_d;
      end
   end
`else
   // Output is steadily on for the whole time the next state is RING
   always_comb begin
      alrmOn_d = (state_d == RING);
   end
`endif

   // State, counters, match history and the registered alarm output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         secCnt_q    <= '0;
         snoozeCnt_q <= '0;
         match_q     <= 1'b0;
         alrmOn_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         secCnt_q    <= secCnt_d;
         snoozeCnt_q <= snoozeCnt_d;
         match_q     <= match;
         alrmOn_q    <= alrmOn_d;
      end
   end

   assign alrm_on    = alrmOn_q;
   assign state      = state_q;
   assign snooze_cnt = snoozeCnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl with short timers (5 s ring, 3 s snooze,
// 2 snoozes): constant vector table, hand sequences and a random run
// against a behavioural model.
module tb_alarm_ctrl;

   localparam int RING_S   = 5;
   localparam int SNOOZE_S = 3;
   localparam int MAX_SNZ  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] cur_hr = '0;
   logic [5:0] cur_min = '0;
   logic       sec_tick = 1'b0;
   logic       set_mode = 1'b0;
   logic       inc_hr = 1'b0;
   logic       inc_min = 1'b0;
   logic       alm_en = 1'b0;
   logic       snooze = 1'b0;
   logic       stop = 1'b0;
   logic [4:0] alm_hr;
   logic [5:0] alm_min;
   logic       alrm_on;
   logic [1:0] state;
   logic [1:0] snooze_cnt;

   int vectors = 0;
   int miscompares = 0;

   alarm_ctrl #(
      .RING_SECS   (RING_S),
      .SNOOZE_SECS (SNOOZE_S),
      .MAX_SNOOZE  (MAX_SNZ)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cur_hr     (cur_hr),
      .cur_min    (cur_min),
      .sec_tick   (sec_tick),
      .set_mode   (set_mode),
      .inc_hr     (inc_hr),
      .inc_min    (inc_min),
      .alm_en     (alm_en),
      .snooze     (snooze),
      .stop       (stop),
      .alm_hr     (alm_hr),
      .alm_min    (alm_min),
      .alrm_on    (alrm_on),
      .state      (state),
      .snooze_cnt (snooze_cnt)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   // Behavioural model: alarm time as integers, a mode number and a count of
   // seconds spent in the current ring/snooze period
   int mHr, mMin, mMode, mElapsed, mSnoozes;
   bit mPrevMatch, mBlink, mOn;

   task automatic modelStep();
      bit m, trig;
      if (rst) begin
         mHr = 0; mMin = 0; mMode = 0; mElapsed = 0; mSnoozes = 0;
         mPrevMatch = 0; mBlink = 1; mOn = 0;
      end else begin
         m    = (int'(cur_hr) == mHr) && (int'(cur_min) == mMin);
         trig = m && !mPrevMatch && alm_en && !set_mode;
         if (set_mode && inc_hr)  mHr  = (mHr + 1) % 24;
         if (set_mode && inc_min) mMin = (mMin + 1) % 60;
         if (!alm_en || set_mode || stop) begin
            mMode = 0; mElapsed = 0; mSnoozes = 0;
         end else if (mMode == 0) begin
            if (trig) begin
               mMode = 1; mElapsed = 0; mSnoozes = 0; mBlink = 1;
            end
         end else if (mMode == 1) begin
            if (sec_tick && (mElapsed + 1 >= RING_S)) begin
               mMode = 0; mElapsed = 0; mSnoozes = 0;
            end else if (snooze && (mSnoozes < MAX_SNZ)) begin
               mMode = 2; mElapsed = 0; mSnoozes++;
            end else if (sec_tick) begin
               mElapsed++;
               mBlink = !mBlink;
            end
         end else begin
            if (sec_tick) begin
               mElapsed++;
               if (mElapsed >= SNOOZE_S) begin
                  mMode = 1; mElapsed = 0; mBlink = 1;
               end
            end
         end
         mPrevMatch = m;
      end
`ifdef ALARM_BLINK_EN
      mOn = (mMode == 1) && mBlink;
`else
      mOn = (mMode == 1);
`endif
   endtask

   // One clock: advance the model on the current inputs, then sample 1 ns after the edge
   task automatic applyStimulus();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll(input string tag, input int eh, input int em, input int est,
                           input int eon, input int ecnt);
      checkOutput({tag, ".alm_hr"},     32'(alm_hr),     32'(eh));
      checkOutput({tag, ".alm_min"},    32'(alm_min),    32'(em));
      checkOutput({tag, ".state"},      32'(state),      32'(est));
      checkOutput({tag, ".alrm_on"},    32'(alrm_on),    32'(eon));
      checkOutput({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(ecnt));
   endtask

   typedef struct {
      bit r, sm, ih, im, en, sz, sp, tk;
      int ch, cm;
      int eHr, eMin, eSt, eOn, eOnB, eCnt;
   } vec_t;

   function automatic vec_t mk(input bit r, sm, ih, im, en, sz, sp, tk, input int ch, cm,
                               input int eh, em, est, eon, eonb, ecnt);
      vec_t v;
      v.r = r; v.sm = sm; v.ih = ih; v.im = im; v.en = en; v.sz = sz; v.sp = sp; v.tk = tk;
      v.ch = ch; v.cm = cm;
      v.eHr = eh; v.eMin = em; v.eSt = est; v.eOn = eon; v.eOnB = eonb; v.eCnt = ecnt;
      return v;
   endfunction

   vec_t tbl[37];

   initial begin
      //           r sm ih im en sz sp tk  ch cm   hr mn st on ob cnt
      tbl[0]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 29,  7, 30, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 1, 1, 1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 1, 1, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 1, 1, 1, 0);
      tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 1, 1, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 1, 1, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 1, 1, 1, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 31,  7, 30, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 1, 1, 1, 0);
      tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 0,  7, 30,  7, 30, 2, 0, 0, 1);
      tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 2, 0, 0, 1);
      tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 2, 0, 0, 1);
      tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 1, 1, 1, 1);
      tbl[16] = mk(0, 0, 0, 0, 1, 1, 0, 0,  7, 30,  7, 30, 2, 0, 0, 2);
      tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 2, 0, 0, 2);
      tbl[18] = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 2, 0, 0, 2);
      tbl[19] = mk(0, 0, 0, 0, 1, 0, 0, 1,  7, 30,  7, 30, 1, 1, 1, 2);
      tbl[20] = mk(0, 0, 0, 0, 1, 1, 0, 0,  7, 30,  7, 30, 1, 1, 1, 2);
      tbl[21] = mk(0, 0, 0, 0, 1, 1, 1, 0,  7, 30,  7, 30, 0, 0, 0, 0);
      tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 31,  7, 30, 0, 0, 0, 0);
      tbl[23] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 1, 1, 1, 0);
      tbl[24] = mk(0, 0, 0, 0, 1, 1, 0, 0,  7, 30,  7, 30, 2, 0, 0, 1);
      tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0,  7, 30,  7, 30, 0, 0, 0, 0);
      tbl[26] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 0, 0, 0, 0);
      tbl[27] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 31,  7, 30, 0, 0, 0, 0);
      tbl[28] = mk(0, 0, 0, 0, 1, 0, 0, 0,  7, 30,  7, 30, 1, 1, 1, 0);
      tbl[29] = mk(0, 0, 0, 0, 1, 1, 0, 0,  7, 30,  7, 30, 2, 0, 0, 1);
      tbl[30] = mk(1, 0, 0, 0, 1, 0, 0, 0,  7, 30,  0,  0, 0, 0, 0, 0);
      tbl[31] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0, 1, 1, 1, 0);
      tbl[32] = mk(0, 0, 0, 0, 1, 0, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      tbl[33] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0,  1,  0,  0, 0, 0, 0, 0);
      tbl[34] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0, 1, 1, 1, 0);
      tbl[35] = mk(0, 1, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      tbl[36] = mk(0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0);

      // Reset state
      rst = 1'b1; cur_hr = 5'd12; cur_min = 6'd0;
      applyStimulus();
      rst = 1'b0;
      checkAll("reset", 0, 0, 0, 0, 0);

      // Step the alarm to 23:59, then one more pulse of each wraps both to zero
      set_mode = 1'b1;
      for (int i = 0; i < 59; i++) begin
         inc_hr = (i < 23); inc_min = 1'b1;
         applyStimulus();
      end
      inc_hr = 1'b0; inc_min = 1'b0;
      applyStimulus();
      checkAll("set_max", 23, 59, 0, 0, 0);
      inc_hr = 1'b1; inc_min = 1'b1;
      applyStimulus();
      checkAll("set_wrap", 0, 0, 0, 0, 0);

      // Pulses outside set mode leave the alarm time alone
      set_mode = 1'b0;
      applyStimulus();
      checkAll("set_ignored", 0, 0, 0, 0, 0);

      // Set the alarm to 07:30
      set_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         inc_hr = (i < 7); inc_min = 1'b1;
         applyStimulus();
      end
      inc_hr = 1'b0; inc_min = 1'b0;
      applyStimulus();
      checkAll("set_0730", 7, 30, 0, 0, 0);

      // Ring, timeout, snooze limits, stop priority, disarm and reset sequences
      for (int i = 0; i < 37; i++) begin
         rst = tbl[i].r; set_mode = tbl[i].sm; inc_hr = tbl[i].ih; inc_min = tbl[i].im;
         alm_en = tbl[i].en; snooze = tbl[i].sz; stop = tbl[i].sp; sec_tick = tbl[i].tk;
         cur_hr = 5'(tbl[i].ch); cur_min = 6'(tbl[i].cm);
         applyStimulus();
`ifdef ALARM_BLINK_EN
         checkAll($sformatf("tbl%0d", i), tbl[i].eHr, tbl[i].eMin, tbl[i].eSt, tbl[i].eOnB, tbl[i].eCnt);
`else
         checkAll($sformatf("tbl%0d", i), tbl[i].eHr, tbl[i].eMin, tbl[i].eSt, tbl[i].eOn, tbl[i].eCnt);
`endif
      end

      // Random run: current time is steered toward the alarm time so events keep happening
      rst = 1'b0; set_mode = 1'b0; alm_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) set_mode = !set_mode;
         if ($urandom_range(0, 59) == 0) alm_en = !alm_en;
         inc_hr   = set_mode && ($urandom_range(0, 3) == 0);
         inc_min  = set_mode && ($urandom_range(0, 3) == 0);
         snooze   = ($urandom_range(0, 7) == 0);
         stop     = ($urandom_range(0, 49) == 0);
         sec_tick = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 9))
            0: begin cur_hr = 5'(mHr); cur_min = 6'(mMin); end
            1: begin cur_hr = 5'(mHr); cur_min = 6'((mMin + 1) % 60); end
            2: begin cur_hr = 5'($urandom_range(0, 23)); cur_min = 6'($urandom_range(0, 59)); end
            default: ;
         endcase
         applyStimulus();
         checkAll($sformatf("rnd%0d", c), mHr, mMin, mMode, int'(mOn), mSnoozes);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm sequencer for the digital clock datapath. It owns the settable alarm time registers (hour/minute) and compares them against the running clock time. It runs a ring/snooze/stop state machine and drives the alarm output. It sits between the debounced button pulses and the alarm indicator, beside digital_clock.

Parameters:
RING_SECS, 60, sec_ticks of ringing before auto-silence
SNOOZE_SECS, 300, sec_ticks spent in SNOOZE before re-ring
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze pulses ignored

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cur_hr  in  5  running clock hour, 0-23
cur_min  in  6  running clock minute, 0-59
sec_tick  in  1  one-cycle pulse per elapsed second
set_mode  in  1  level; 1 = inc_hr/inc_min edit the alarm time
inc_hr  in  1  debounced one-cycle pulse
inc_min  in  1  debounced one-cycle pulse
alm_en  in  1  level; alarm armed
snooze  in  1  debounced one-cycle pulse
stop  in  1  debounced one-cycle pulse
alm_hr  out  5  alarm hour register
alm_min  out  6  alarm minute register
alrm_on  out  1  alarm sounding
state  out  2  FSM state: 0 IDLE, 1 RING, 2 SNOOZE
snooze_cnt  out  2  snoozes used in the current event

Behaviour:
- Reset (sync, rst=1 at posedge): alm_hr=0, alm_min=0, state=IDLE, alrm_on=0, snooze_cnt=0, internal match_q=0, sec counter=0. rst overrides all other inputs.
- Alarm set: runs only when set_mode=1.
  - inc_hr: alm_hr <= (alm_hr==23) ? 0 : alm_hr+1.
  - inc_min: alm_min <= (alm_min==59) ? 0 : alm_min+1.
  - Both pulses in the same cycle: both apply.
  - Pulses while set_mode=0 are ignored.
- match = (cur_hr==alm_hr) && (cur_min==alm_min). match_q <= match every cycle.
- trigger = match & ~match_q & alm_en & ~set_mode. Rising edge only, so stopping within the matched minute does not retrigger.
- Priority order, every cycle, in any state: (1) rst; (2) ~alm_en or set_mode -> IDLE, snooze_cnt=0; (3) stop -> IDLE, snooze_cnt=0; (4) per-state rules below.
- IDLE: trigger -> RING, sec counter cleared, snooze_cnt=0.
- RING: sec counter counts sec_tick.
  - Counter reaches RING_SECS -> IDLE, snooze_cnt=0.
  - snooze pulse with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, counter cleared.
  - snooze pulse with snooze_cnt==MAX_SNOOZE: ignored, stays in RING.
- SNOOZE: counts sec_tick; reaching SNOOZE_SECS -> RING, counter cleared. A trigger in SNOOZE or RING is ignored.
- snooze and stop in the same cycle: stop wins.
- Latency: alrm_on is registered. It rises on the clock edge after the first cycle in which match=1 (one cycle after cur_min updates), and falls on the edge after stop.
- alrm_on = (next state==RING), registered; state output is the registered FSM state.
- Changing alm_hr/alm_min in set_mode cannot cause a trigger, because set_mode blocks it. On leaving set_mode with the time already matching, match_q is already 1, so there is no trigger.
- Sec counter width: $clog2(max(RING_SECS,SNOOZE_SECS)+1).

Optional Feature:
ALARM_BLINK_EN:
- Defined: an internal blink bit toggles on each sec_tick while in RING and resets to 1 on RING entry; alrm_on = RING & blink (1 s on / 1 s off).
- Undefined: alrm_on is steady 1 throughout RING.

Decomposition:
- Package alarm_pkg: state enum typedef (IDLE/RING/SNOOZE, 2-bit), HR_MAX=23, MIN_MAX=59, hour/minute width constants.
- One sub-module, alarm_time_reg: set_mode/inc_hr/inc_min handling with mod-24/mod-60 wrap, outputs alm_hr/alm_min.

Test Plan (RING_SECS=5, SNOOZE_SECS=3, MAX_SNOOZE=2):
- set_mode=1, alm_hr=23, 1 inc_hr pulse -> alm_hr=0; alm_min=59, 1 inc_min pulse -> alm_min=0; pulses with set_mode=0 -> no change.
- Alarm 07:30, alm_en=1, cur time steps 07:29->07:30 -> alrm_on=1 one cycle later; after 5 sec_ticks -> alrm_on=0, state=IDLE, no retrigger while cur_min stays 30.
- Ringing; snooze -> SNOOZE, snooze_cnt=1; 3 sec_ticks -> RING; snooze -> cnt=2; snooze again -> ignored, stays RING.
- Ringing; snooze and stop in the same cycle -> IDLE, alrm_on=0, snooze_cnt=0.
- Ringing; drop alm_en or assert rst mid-SNOOZE -> IDLE next edge; rst also clears alm_hr/alm_min to 0.
- ALARM_BLINK_EN defined: during RING, alrm_on toggles on each sec_tick starting at 1.
